// File: rtl/pio_noc_bridge_pkg.sv
// -----------------------------------------------------------------------------
// noc_bridge_pkg
// Shared constants for the PIO <-> NoC bridge: field widths, bit positions of
// the control/status fields inside the 8-bit addr PIOs, and the FIFO entry
// layout {node, data}.
// -----------------------------------------------------------------------------
package noc_bridge_pkg;

    localparam int NODE_W = 4;
    localparam int WORD_W = 32;
    localparam int ENTRY_W = NODE_W + WORD_W;

    // addr_pio_out (software -> bridge)
    localparam int DEST_LSB   = 0;
    localparam int DEST_MSB   = 3;
    localparam int RX_ACK_BIT = 6;
    localparam int TX_REQ_BIT = 7;

    // addr_pio_in (bridge -> software); [3:0] reuses DEST_LSB/MSB for RX src
    localparam int TX_FULL_BIT  = 5;
    localparam int RX_VALID_BIT = 6;
    localparam int TX_ACK_BIT   = 7;

    // One FIFO entry: TX holds the destination, RX holds the source.
    typedef struct packed {
        logic [NODE_W-1:0] node;
        logic [WORD_W-1:0] data;
    } noc_word_t;

endpackage

// File: rtl/pio_noc_bridge_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Show-ahead synchronous FIFO. o_dout always shows the head entry; a pop
// advances to the next entry on the following cycle. Pointers carry one extra
// wrap bit so full/empty come from a simple compare.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (pointers only)
//   i_push, i_din     write request and data (ignored when full)
//   i_pop             read request (ignored when empty)
//   o_dout            head entry (undefined content when empty)
//   o_full, o_empty   status
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
        end
    end

    // Storage is not reset; emptiness is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_din;
    end

    // Same index with differing wrap bits means the writer lapped the reader.
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_dout  = r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/pio_noc_bridge.sv
// -----------------------------------------------------------------------------
// pio_noc_bridge
// Lets a Nios II core exchange 32-bit words with a NoC router through two PIOs.
// Software signals "send" and "consumed" by toggling bits in addr_pio_out; the
// bridge answers with a tx_ack toggle and RX status bits in addr_pio_in.
// Ports:
//   clk_clk, reset_reset_n        clock, asynchronous active-low reset
//   addr_pio_out[7:0]             [3:0] dest, [6] rx_ack toggle, [7] tx_req toggle
//   data_pio_out[31:0]            TX payload
//   addr_pio_in[7:0]              [3:0] RX src, [5] tx_full, [6] rx_valid, [7] tx_ack
//   data_pio_in[31:0]             RX head payload (0 when RX empty)
//   noc_tx_valid/ready/data/dest/src   router TX port (valid/ready)
//   noc_rx_valid/ready/data/src        router RX port (valid/ready)
// -----------------------------------------------------------------------------
module pio_noc_bridge
    import noc_bridge_pkg::*;
#(
    parameter logic [NODE_W-1:0] NODE_ID  = '0,
    parameter int                TX_DEPTH = 4,
    parameter int                RX_DEPTH = 4
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [7:0]        addr_pio_out,
    input  logic [WORD_W-1:0] data_pio_out,
    output logic [7:0]        addr_pio_in,
    output logic [WORD_W-1:0] data_pio_in,
    output logic              noc_tx_valid,
    input  logic              noc_tx_ready,
    output logic [WORD_W-1:0] noc_tx_data,
    output logic [NODE_W-1:0] noc_tx_dest,
    output logic [NODE_W-1:0] noc_tx_src,
    input  logic              noc_rx_valid,
    output logic              noc_rx_ready,
    input  logic [WORD_W-1:0] noc_rx_data,
    input  logic [NODE_W-1:0] noc_rx_src
);

    logic      r_prev_req;
    logic      r_prev_ack;
    logic      r_tx_pend;
    logic      r_tx_ack;
    noc_word_t r_pend_word;

    logic      w_req_ev;
    logic      w_ack_ev;
    noc_word_t w_req_word;
    noc_word_t w_tx_din;
    noc_word_t w_tx_head;
    noc_word_t w_rx_din;
    noc_word_t w_rx_head;
    logic      w_push_pend;
    logic      w_push_direct;
    logic      w_capture;
    logic      w_tx_push;
    logic      w_tx_pop;
    logic      w_tx_full;
    logic      w_tx_empty;
    logic      w_rx_push;
    logic      w_rx_pop;
    logic      w_rx_full;
    logic      w_rx_empty;
    logic      w_unused_bits;

    assign w_unused_bits = ^addr_pio_out[5:4];

    // Software and bridge share the clock, so a plain XOR against last
    // cycle's value is a clean one-cycle event.
    assign w_req_ev = addr_pio_out[TX_REQ_BIT] ^ r_prev_req;
    assign w_ack_ev = addr_pio_out[RX_ACK_BIT] ^ r_prev_ack;

    assign w_req_word.node = addr_pio_out[DEST_MSB:DEST_LSB];
    assign w_req_word.data = data_pio_out;

    // A pending word has priority; a new request while one is pending is a
    // protocol violation and is dropped.
    assign w_push_pend   = r_tx_pend && !w_tx_full;
    assign w_push_direct = w_req_ev && !r_tx_pend && !w_tx_full;
    assign w_capture     = w_req_ev && !r_tx_pend && w_tx_full;
    assign w_tx_push     = w_push_pend || w_push_direct;
    assign w_tx_din      = r_tx_pend ? r_pend_word : w_req_word;
    assign w_tx_pop      = noc_tx_valid && noc_tx_ready;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_prev_req <= 1'b0;
            r_prev_ack <= 1'b0;
            r_tx_pend  <= 1'b0;
            r_tx_ack   <= 1'b0;
        end else begin
            r_prev_req <= addr_pio_out[TX_REQ_BIT];
            r_prev_ack <= addr_pio_out[RX_ACK_BIT];
            if (w_capture)        r_tx_pend <= 1'b1;
            else if (w_push_pend) r_tx_pend <= 1'b0;
            if (w_tx_push)        r_tx_ack  <= ~r_tx_ack;
        end
    end

    // Payload only; r_tx_pend qualifies it, so no reset needed.
    always_ff @(posedge clk_clk) begin
        if (w_capture) r_pend_word <= w_req_word;
    end

    sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .i_push  (w_tx_push),
        .i_din   (w_tx_din),
        .i_pop   (w_tx_pop),
        .o_dout  (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    assign w_rx_din.node = noc_rx_src;
    assign w_rx_din.data = noc_rx_data;
    assign w_rx_push     = noc_rx_valid && !w_rx_full;
    assign w_rx_pop      = w_ack_ev && !w_rx_empty;

    sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .i_push  (w_rx_push),
        .i_din   (w_rx_din),
        .i_pop   (w_rx_pop),
        .o_dout  (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    // Head data is masked when empty so stale storage never leaks out.
    assign noc_tx_valid = !w_tx_empty;
    assign noc_tx_data  = w_tx_empty ? '0 : w_tx_head.data;
    assign noc_tx_dest  = w_tx_empty ? '0 : w_tx_head.node;
    assign noc_tx_src   = NODE_ID;
    assign noc_rx_ready = !w_rx_full;
    assign data_pio_in  = w_rx_empty ? '0 : w_rx_head.data;

    always_comb begin
        addr_pio_in                    = '0;
        addr_pio_in[DEST_MSB:DEST_LSB] = w_rx_empty ? '0 : w_rx_head.node;
        addr_pio_in[TX_FULL_BIT]       = w_tx_full || r_tx_pend;
        addr_pio_in[RX_VALID_BIT]      = !w_rx_empty;
        addr_pio_in[TX_ACK_BIT]        = r_tx_ack;
    end

endmodule

// File: tb/tb_pio_noc_bridge.sv
module tb_pio_noc_bridge;

    localparam logic [3:0] NID = 4'd6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  addr_pio_out;
    logic [31:0] data_pio_out;
    logic [7:0]  addr_pio_in;
    logic [31:0] data_pio_in;
    logic        noc_tx_valid;
    logic        noc_tx_ready;
    logic [31:0] noc_tx_data;
    logic [3:0]  noc_tx_dest;
    logic [3:0]  noc_tx_src;
    logic        noc_rx_valid;
    logic        noc_rx_ready;
    logic [31:0] noc_rx_data;
    logic [3:0]  noc_rx_src;

    pio_noc_bridge #(.NODE_ID(NID), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .addr_pio_out  (addr_pio_out),
        .data_pio_out  (data_pio_out),
        .addr_pio_in   (addr_pio_in),
        .data_pio_in   (data_pio_in),
        .noc_tx_valid  (noc_tx_valid),
        .noc_tx_ready  (noc_tx_ready),
        .noc_tx_data   (noc_tx_data),
        .noc_tx_dest   (noc_tx_dest),
        .noc_tx_src    (noc_tx_src),
        .noc_rx_valid  (noc_rx_valid),
        .noc_rx_ready  (noc_rx_ready),
        .noc_rx_data   (noc_rx_data),
        .noc_rx_src    (noc_rx_src)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [35:0] txq[$];
    logic [35:0] rxq[$];
    logic        exp_ack;
    logic        mon_prev6;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] dest, input logic [31:0] data);
        addr_pio_out[3:0] = dest;
        data_pio_out      = data;
        addr_pio_out[7]   = ~addr_pio_out[7];
        txq.push_back({dest, data});
        tick();
    endtask

    task automatic ack();
        addr_pio_out[6] = ~addr_pio_out[6];
        tick();
    endtask

    task automatic rx_word(input logic [3:0] src, input logic [31:0] data);
        chk("rx_ready_before_push", 64'(noc_rx_ready), 64'd1);
        noc_rx_valid = 1'b1;
        noc_rx_src   = src;
        noc_rx_data  = data;
        rxq.push_back({src, data});
        tick();
        noc_rx_valid = 1'b0;
    endtask

    initial begin
        logic [35:0] exp_w;
        rst_n        = 1'b0;
        addr_pio_out = '0;
        data_pio_out = '0;
        noc_tx_ready = 1'b0;
        noc_rx_valid = 1'b0;
        noc_rx_data  = '0;
        noc_rx_src   = '0;
        exp_ack      = 1'b0;
        mon_prev6    = 1'b0;

        // Monitor: checks router-side TX handshakes and software-side RX
        // consumption against the expected-word queues.
        fork
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    if (noc_tx_valid && noc_tx_ready) begin
                        if (txq.size() == 0) begin
                            total++; bad++;
                            $display("FAIL tx_unexpected: got %0h expected none", {noc_tx_dest, noc_tx_data});
                        end else begin
                            exp_w = txq.pop_front();
                            chk("tx_word", 64'({noc_tx_dest, noc_tx_data}), 64'(exp_w));
                        end
                    end
                    if ((addr_pio_out[6] != mon_prev6) && addr_pio_in[6]) begin
                        if (rxq.size() == 0) begin
                            total++; bad++;
                            $display("FAIL rx_unexpected: got %0h expected none", {addr_pio_in[3:0], data_pio_in});
                        end else begin
                            exp_w = rxq.pop_front();
                            chk("rx_word", 64'({addr_pio_in[3:0], data_pio_in}), 64'(exp_w));
                        end
                    end
                end
                mon_prev6 = addr_pio_out[6];
            end
        join_none

        // Reset values
        #12;
        chk("rst_addr_pio_in", 64'(addr_pio_in), 64'h0);
        chk("rst_data_pio_in", 64'(data_pio_in), 64'h0);
        chk("rst_tx_valid", 64'(noc_tx_valid), 64'h0);
        chk("rst_tx_data", 64'({noc_tx_dest, noc_tx_data}), 64'h0);
        chk("rst_tx_src", 64'(noc_tx_src), 64'(NID));
        chk("rst_rx_ready", 64'(noc_rx_ready), 64'h1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // Single send
        send(4'd3, 32'hDEADBEEF);
        exp_ack = ~exp_ack;
        chk("single_tx_valid", 64'(noc_tx_valid), 64'h1);
        chk("single_tx_head", 64'({noc_tx_dest, noc_tx_data}), 64'h3DEADBEEF);
        chk("single_tx_ack", 64'(addr_pio_in[7]), 64'(exp_ack));
        chk("single_tx_full", 64'(addr_pio_in[5]), 64'h0);
        noc_tx_ready = 1'b1;
        tick();
        noc_tx_ready = 1'b0;
        chk("single_drained", 64'(noc_tx_valid), 64'h0);

        // Backpressure: 4 accepted, 5th pending
        for (int i = 0; i < 5; i++) begin
            send(4'(i + 1), 32'hA000_0000 + 32'(i));
            if (i < 4) exp_ack = ~exp_ack;
            chk("bp_ack", 64'(addr_pio_in[7]), 64'(exp_ack));
        end
        chk("bp_tx_full", 64'(addr_pio_in[5]), 64'h1);
        tick();
        chk("bp_no_5th_ack", 64'(addr_pio_in[7]), 64'(exp_ack));
        noc_tx_ready = 1'b1;
        tick();
        noc_tx_ready = 1'b0;
        chk("bp_still_full_pend", 64'(addr_pio_in[5]), 64'h1);
        tick();
        exp_ack = ~exp_ack;
        chk("bp_5th_ack", 64'(addr_pio_in[7]), 64'(exp_ack));
        noc_tx_ready = 1'b1;
        repeat (4) tick();
        noc_tx_ready = 1'b0;
        chk("bp_empty", 64'(noc_tx_valid), 64'h0);
        chk("bp_full_clear", 64'(addr_pio_in[5]), 64'h0);

        // RX two words
        rx_word(4'd2, 32'h11111111);
        chk("rx_first_visible", 64'({addr_pio_in[6], addr_pio_in[3:0], data_pio_in}), 64'h1_2_11111111);
        rx_word(4'd5, 32'h22222222);
        ack();
        chk("rx_second_head", 64'({addr_pio_in[6], addr_pio_in[3:0], data_pio_in}), 64'h1_5_22222222);
        ack();
        chk("rx_empty_after_acks", 64'({addr_pio_in[6], addr_pio_in[3:0], data_pio_in}), 64'h0);

        // RX full
        for (int i = 1; i <= 4; i++) rx_word(4'(i), 32'h3000_0000 + 32'(i));
        chk("rxf_ready_low", 64'(noc_rx_ready), 64'h0);
        noc_rx_valid = 1'b1;
        noc_rx_src   = 4'hA;
        noc_rx_data  = 32'h3000_0005;
        rxq.push_back({4'hA, 32'h3000_0005});
        tick();
        chk("rxf_stalled", 64'(noc_rx_ready), 64'h0);
        addr_pio_out[6] = ~addr_pio_out[6];
        tick();
        chk("rxf_ready_back", 64'(noc_rx_ready), 64'h1);
        tick();
        noc_rx_valid = 1'b0;
        chk("rxf_full_again", 64'(noc_rx_ready), 64'h0);
        repeat (4) ack();
        chk("rxf_drained", 64'(addr_pio_in[6]), 64'h0);

        // Simultaneous req + ack, then ack on empty RX
        rx_word(4'd7, 32'h55555555);
        addr_pio_out[3:0] = 4'd9;
        data_pio_out      = 32'h66666666;
        addr_pio_out[7]   = ~addr_pio_out[7];
        addr_pio_out[6]   = ~addr_pio_out[6];
        txq.push_back({4'd9, 32'h66666666});
        tick();
        exp_ack = ~exp_ack;
        chk("sim_tx_ack", 64'(addr_pio_in[7]), 64'(exp_ack));
        chk("sim_tx_head", 64'({noc_tx_valid, noc_tx_dest, noc_tx_data}), 64'h1_9_66666666);
        chk("sim_rx_popped", 64'(addr_pio_in[6]), 64'h0);
        noc_tx_ready = 1'b1;
        tick();
        noc_tx_ready = 1'b0;
        ack();
        chk("empty_ack_status", 64'(addr_pio_in), 64'({exp_ack, 7'b0}));
        chk("empty_ack_data", 64'(data_pio_in), 64'h0);
        chk("empty_ack_ready", 64'(noc_rx_ready), 64'h1);

        // Reset mid-operation
        send(4'd1, 32'h81);
        send(4'd2, 32'h82);
        for (int i = 0; i < 3; i++) rx_word(4'(i), 32'h9000_0000 + 32'(i));
        chk("pre_rst_busy", 64'({noc_tx_valid, addr_pio_in[6]}), 64'h3);
        #2;
        rst_n        = 1'b0;
        addr_pio_out = '0;
        #1;
        chk("arst_addr_pio_in", 64'(addr_pio_in), 64'h0);
        chk("arst_data_pio_in", 64'(data_pio_in), 64'h0);
        chk("arst_tx", 64'({noc_tx_valid, noc_tx_dest, noc_tx_data}), 64'h0);
        chk("arst_rx_ready", 64'(noc_rx_ready), 64'h1);
        txq.delete();
        rxq.delete();
        exp_ack = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        chk("post_rst_status", 64'({noc_tx_valid, addr_pio_in, data_pio_in}), 64'h0);
        send(4'd4, 32'h77777777);
        exp_ack = ~exp_ack;
        chk("post_rst_ack", 64'(addr_pio_in[7]), 64'(exp_ack));
        noc_tx_ready = 1'b1;
        tick();
        noc_tx_ready = 1'b0;
        chk("post_rst_drained", 64'(noc_tx_valid), 64'h0);

        chk("txq_consumed", 64'(txq.size()), 64'h0);
        chk("rxq_consumed", 64'(rxq.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
